// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory: LEN_HI, LEN_LO, 4*N payload bytes, CSUM.
// Packs bytes big-endian into words, writes them at consecutive addresses and holds the core in reset while loading.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  logic [2:0]  state_reg, state_next;
  logic [7:0]  len_hi_reg, len_hi_next;
  logic [15:0] len_reg, len_next;
  logic [7:0]  sum_reg, sum_next;
  logic [1:0]  idx_reg, idx_next;
  logic [15:0] words_reg, words_next;
  logic        in_ready_reg, in_ready_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic        hold_reg, hold_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  logic [23:0] lane_reg, lane_next;
  logic        xfer;
  logic        shift_en;
  logic [15:0] len_full;
  logic [15:0] words_inc;

  assign xfer      = in_valid & in_ready_reg;
  assign shift_en  = xfer && (state_reg == S_DATA);
  assign len_full  = {len_hi_reg, in_byte};
  assign words_inc = 16'(words_reg + 16'd1);

  // Byte lanes of the word being assembled; lane 0 holds the most recent byte.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign lane_next[7:0] = shift_en ? in_byte : lane_reg[7:0];
      end else begin : g_rest
        assign lane_next[gi*8 +: 8] = shift_en ? lane_reg[(gi-1)*8 +: 8] : lane_reg[gi*8 +: 8];
      end
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    len_hi_next    = len_hi_reg;
    len_next       = len_reg;
    sum_next       = sum_reg;
    idx_next       = idx_reg;
    words_next     = words_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    hold_next      = hold_reg;
    done_next      = done_reg;
    err_next       = err_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_next = S_LEN_HI;
          done_next  = 1'b0;
          err_next   = 1'b0;
          words_next = 16'd0;
          sum_next   = 8'd0;
          idx_next   = 2'd0;
          hold_next  = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_next = in_byte;
          sum_next    = 8'(sum_reg + in_byte);
          state_next  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_next = len_full;
          sum_next = 8'(sum_reg + in_byte);
          if (len_full > MAX_W) begin
            state_next = S_ERR;
            err_next   = 1'b1;
            hold_next  = 1'b0;
          end else if (len_full == 16'd0) begin
            state_next = S_CSUM;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          sum_next = 8'(sum_reg + in_byte);
          idx_next = 2'(idx_reg + 2'd1);
          if (idx_reg == 2'd3) begin
            state_next     = S_WRITE;
            mem_we_next    = 1'b1;
            mem_addr_next  = BASE_ADDR + {14'd0, words_reg, 2'b00};
            mem_wdata_next = {lane_reg, in_byte};
          end
        end
      end
      S_WRITE: begin
        words_next = words_inc;
        state_next = (words_inc == len_reg) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) begin
          hold_next = 1'b0;
          if (in_byte == sum_reg) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = S_ERR;
            err_next   = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Registered ready: decoded from the state being entered.
    in_ready_next = (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                    (state_next == S_DATA)   || (state_next == S_CSUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      len_hi_reg    <= 8'd0;
      len_reg       <= 16'd0;
      sum_reg       <= 8'd0;
      idx_reg       <= 2'd0;
      words_reg     <= 16'd0;
      lane_reg      <= 24'd0;
      in_ready_reg  <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= BASE_ADDR;
      mem_wdata_reg <= 32'd0;
      hold_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_hi_reg    <= len_hi_next;
      len_reg       <= len_next;
      sum_reg       <= sum_next;
      idx_reg       <= idx_next;
      words_reg     <= words_next;
      lane_reg      <= lane_next;
      in_ready_reg  <= in_ready_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      hold_reg      <= hold_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign in_ready      = in_ready_reg;
  assign mem_we        = mem_we_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign hold          = hold_reg;
  assign done          = done_reg;
  assign err           = err_reg;
  assign words_written = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames against a frame-level reference model of the loader.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [7:0] TWO [11] = '{8'h00, 8'h02, 8'h06, 8'h40, 8'h02, 8'h93,
                                       8'h00, 8'h00, 8'h81, 8'h13, 8'h71};

  typedef logic [7:0] byteq_t [$];
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready, mem_we, hold, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_written;

  int nassert = 0;
  int nfail = 0;
  wr_t got[$];
  wr_t expw[$];

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(250)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .hold(hold), .done(done), .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no end expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      got.push_back('{addr: mem_addr, data: mem_wdata});
      $display("write addr=%h data=%h", mem_addr, mem_wdata);
      chk("ready_during_write", {31'd0, in_ready}, 32'd0);
    end
  end

  // Reference: parse the frame by its rules and derive writes and outcome.
  function automatic void model(input byteq_t f, output int nsend, output bit edone,
                                output bit eerr, output int ewords);
    int n;
    int sum;
    n = int'(f[0]) * 256 + int'(f[1]);
    expw.delete();
    if (n > 250) begin
      nsend = 2; edone = 0; eerr = 1; ewords = 0;
      return;
    end
    for (int i = 0; i < n; i++)
      expw.push_back('{addr: BASE + 32'(4 * i),
                       data: {f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]}});
    sum = 0;
    for (int j = 0; j < f.size() - 1; j++) sum += int'(f[j]);
    nsend  = f.size();
    edone  = ((sum % 256) == int'(f[f.size()-1]));
    eerr   = !edone;
    ewords = n;
  endfunction

  function automatic byteq_t mk_frame(input int n, input bit bad);
    byteq_t q;
    int sum;
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    if (n <= 250)
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom_range(0, 255)));
    sum = 0;
    foreach (q[i]) sum += int'(q[i]);
    q.push_back(8'(sum + (bad ? 1 : 0)));
    return q;
  endfunction

  function automatic byteq_t two_frame();
    byteq_t q;
    for (int i = 0; i < 11; i++) q.push_back(TWO[i]);
    return q;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    budget = 0;
    @(negedge clk);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_hold", {31'd0, hold}, 32'd1);
    chk("start_ready", {31'd0, in_ready}, 32'd1);
    chk("start_done_clr", {31'd0, done}, 32'd0);
    chk("start_err_clr", {31'd0, err}, 32'd0);
    chk("start_words_clr", {16'd0, words_written}, 32'd0);
  endtask

  task automatic run_frame(input string tag, input byteq_t f, input bit gaps);
    int nsend, ewords;
    bit edone, eerr;
    model(f, nsend, edone, eerr, ewords);
    got.delete();
    do_start();
    for (int i = 0; i < nsend; i++) send_byte(f[i], gaps);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, {31'd0, edone});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
    chk({tag, "_hold"}, {31'd0, hold}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_words"}, {16'd0, words_written}, 32'(ewords));
    chk({tag, "_nwrites"}, 32'(got.size()), 32'(expw.size()));
    for (int i = 0; i < expw.size(); i++) begin
      if (i < got.size()) begin
        chk({tag, "_addr"}, got[i].addr, expw[i].addr);
        chk({tag, "_data"}, got[i].data, expw[i].data);
      end
    end
    $display("frame %s: bytes=%0d writes=%0d done=%0b err=%0b", tag, nsend, got.size(), done, err);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"}, mem_addr, BASE);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_hold"}, {31'd0, hold}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_words"}, {16'd0, words_written}, 32'd0);
  endtask

  initial begin
    byteq_t f;
    int n;
    bit bad;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 32'd0);
    chk("idle_hold", {31'd0, hold}, 32'd0);

    run_frame("two_word", two_frame(), 1'b0);

    f = two_frame();
    f[10] = 8'h72;
    run_frame("bad_csum", f, 1'b0);

    f = mk_frame(251, 1'b0);
    run_frame("too_long", f, 1'b0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("too_long_ready_stays", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    f = mk_frame(0, 1'b0);
    run_frame("zero_len", f, 1'b0);

    run_frame("backpressure", two_frame(), 1'b1);

    // Asynchronous reset in the middle of the two-word frame.
    got.delete();
    f = two_frame();
    do_start();
    for (int i = 0; i < 6; i++) send_byte(f[i], 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("post_rst_hold", {31'd0, hold}, 32'd0);
    run_frame("after_rst", two_frame(), 1'b0);

    for (int r = 0; r < 6; r++) begin
      n   = (r == 5) ? int'($urandom_range(251, 400)) : int'($urandom_range(1, 6));
      bad = ($urandom_range(0, 2) == 0);
      f   = mk_frame(n, bad);
      run_frame($sformatf("rand%0d", r), f, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
